// File: rtl/axi_line_pkg.sv
// Shared definitions for the AXI-style line responder.
// Holds the line geometry and the read/write channel FSM state encodings.
package axi_line_pkg;

  localparam int unsigned LINE_WORDS    = 16;
  localparam int unsigned LINE_OFFSET_W = 6;
  localparam int unsigned BEAT_W        = 4;

  typedef enum logic [1:0] {
    RIdle = 2'd0,
    RWait = 2'd1,
    RData = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WIdle = 2'd0,
    WData = 2'd1,
    WResp = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_line_responder_ram.sv
// Word-addressed backing RAM for the line responder.
// Ports: clk_i/rst_i; synchronous read port (re_i, raddr_i -> rdata_o, registered);
// byte-enabled synchronous write port (we_i, waddr_i, wdata_i, wstrb_i).
// A read and a write of the same word in one cycle returns the old word.
module line_ram #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i
);

  logic [31:0] mem_q [0:(2**ADDR_W)-1];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && wstrb_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Output register holds its value when no read is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_line_responder.sv
// AXI-style responder serving 16-beat line reads and strobed 16-beat line writes
// from an on-chip word RAM.
// Read channel : r_req_i/r_addr_i/r_rdy_o address, ret_valid_o/ret_last_o/r_data_o beats
//                accepted by r_data_ready_i.
// Write channel: w_req_i/w_addr_i/w_rdy_o address, w_data_req_i/w_data_i/w_strb_i/w_last_i
//                beats accepted by w_data_ready_o, b_valid_o/b_ready_i response.
// wr_err_o is a sticky flag for a w_last that does not coincide with beat 15.
module axi_line_responder
  import axi_line_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned LINE_WORDS = axi_line_pkg::LINE_WORDS,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        r_req_i,
  input  logic [31:0] r_addr_i,
  output logic        r_rdy_o,
  output logic        ret_valid_o,
  output logic        ret_last_o,
  output logic [31:0] r_data_o,
  input  logic        r_data_ready_i,
  input  logic        w_req_i,
  input  logic [31:0] w_addr_i,
  output logic        w_rdy_o,
  input  logic        w_data_req_i,
  input  logic [31:0] w_data_i,
  input  logic [3:0]  w_strb_i,
  input  logic        w_last_i,
  output logic        w_data_ready_o,
  output logic        b_valid_o,
  input  logic        b_ready_i,
  output logic        wr_err_o
);

  localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  // The RAM load happens in the last wait cycle, so the counter starts one short.
  localparam logic [CntW-1:0]   WaitInit = (RD_LATENCY > 0) ? CntW'(RD_LATENCY - 1) : '0;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_WORDS - 1);

  function automatic logic [ADDR_W-1:0] line_base(input logic [31:0] addr);
    return {addr[ADDR_W+1:LINE_OFFSET_W], {BEAT_W{1'b0}}};
  endfunction

  logic unused_addr;
  assign unused_addr = ^{r_addr_i[31:ADDR_W+2], r_addr_i[LINE_OFFSET_W-1:0],
                         w_addr_i[31:ADDR_W+2], w_addr_i[LINE_OFFSET_W-1:0]};

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
  logic [CntW-1:0]   wait_q, wait_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
  logic              wr_err_q, wr_err_d;

  logic              ram_re, ram_we;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= RIdle;
      rd_base_q  <= '0;
      rd_beat_q  <= '0;
      wait_q     <= '0;
      wr_state_q <= WIdle;
      wr_base_q  <= '0;
      wr_beat_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_base_q  <= rd_base_d;
      rd_beat_q  <= rd_beat_d;
      wait_q     <= wait_d;
      wr_state_q <= wr_state_d;
      wr_base_q  <= wr_base_d;
      wr_beat_q  <= wr_beat_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Read channel: r_data is loaded one cycle ahead of the beat it presents.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_base_d  = rd_base_q;
    rd_beat_d  = rd_beat_q;
    wait_d     = wait_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_base_q;
    unique case (rd_state_q)
      RIdle: begin
        if (r_req_i) begin
          rd_base_d = line_base(r_addr_i);
          rd_beat_d = '0;
          wait_d    = WaitInit;
          if (RD_LATENCY == 0) begin
            ram_re     = 1'b1;
            ram_raddr  = line_base(r_addr_i);
            rd_state_d = RData;
          end else begin
            rd_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (wait_q == '0) begin
          ram_re     = 1'b1;
          rd_state_d = RData;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RData: begin
        if (r_data_ready_i) begin
          if (rd_beat_q == LastBeat) begin
            rd_state_d = RIdle;
          end else begin
            rd_beat_d = rd_beat_q + 1'b1;
            ram_re    = 1'b1;
            ram_raddr = rd_base_q + ADDR_W'(rd_beat_d);
          end
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  // Write channel: a burst ends on w_last or on beat 15, whichever is first.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_base_d  = wr_base_q;
    wr_beat_d  = wr_beat_q;
    wr_err_d   = wr_err_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_base_q + ADDR_W'(wr_beat_q);
    unique case (wr_state_q)
      WIdle: begin
        if (w_req_i) begin
          wr_base_d  = line_base(w_addr_i);
          wr_beat_d  = '0;
          wr_state_d = WData;
        end
      end
      WData: begin
        if (w_data_req_i) begin
          ram_we    = 1'b1;
          wr_beat_d = wr_beat_q + 1'b1;
          if (w_last_i || (wr_beat_q == LastBeat)) begin
            wr_state_d = WResp;
            if (w_last_i != (wr_beat_q == LastBeat)) begin
              wr_err_d = 1'b1;
            end
          end
        end
      end
      WResp: begin
        if (b_ready_i) begin
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  line_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (r_data_o),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (w_data_i),
    .wstrb_i (w_strb_i)
  );

  assign r_rdy_o        = (rd_state_q == RIdle);
  assign ret_valid_o    = (rd_state_q == RData);
  assign ret_last_o     = (rd_state_q == RData) && (rd_beat_q == LastBeat);
  assign w_rdy_o        = (wr_state_q == WIdle);
  assign w_data_ready_o = (wr_state_q == WData);
  assign b_valid_o      = (wr_state_q == WResp);
  assign wr_err_o       = wr_err_q;

endmodule

// File: tb/tb_axi_line_responder.sv
// Directed bench for axi_line_responder: line reads with and without back-pressure,
// strobed and short write bursts, read/write collision and reset in mid-burst.
module tb_axi_line_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_req = 1'b0;
  logic [31:0] r_addr = '0;
  logic        r_rdy, ret_valid, ret_last;
  logic [31:0] r_data;
  logic        r_data_ready = 1'b1;
  logic        w_req = 1'b0;
  logic [31:0] w_addr = '0;
  logic        w_rdy;
  logic        w_data_req = 1'b0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        w_data_ready, b_valid;
  logic        b_ready = 1'b0;
  logic        wr_err;

  int n_cmp = 0;
  int n_err = 0;

  // Expected contents of words 0..63 (lines 0x000..0x0C0).
  logic [31:0] exp_mem [0:63];

  always #5 clk = ~clk;

  axi_line_responder #(
    .ADDR_W     (14),
    .LINE_WORDS (16),
    .RD_LATENCY (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .r_req_i        (r_req),
    .r_addr_i       (r_addr),
    .r_rdy_o        (r_rdy),
    .ret_valid_o    (ret_valid),
    .ret_last_o     (ret_last),
    .r_data_o       (r_data),
    .r_data_ready_i (r_data_ready),
    .w_req_i        (w_req),
    .w_addr_i       (w_addr),
    .w_rdy_o        (w_rdy),
    .w_data_req_i   (w_data_req),
    .w_data_i       (w_data),
    .w_strb_i       (w_strb),
    .w_last_i       (w_last),
    .w_data_ready_o (w_data_ready),
    .b_valid_o      (b_valid),
    .b_ready_i      (b_ready),
    .wr_err_o       (wr_err)
  );

`define CHK(tag, obs, exp) \
  begin \
    n_cmp++; \
    assert ((obs) === (exp)) else begin \
      n_err++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

  initial begin
    #500000;
    n_err++;
    $error("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Write burst: beat k carries dbase+k, strobe strb0 on beat 0 and strb afterwards,
  // w_last on beat last_at; b_ready is held off for bdelay cycles.
  task automatic wr_burst(input logic [31:0] addr, input logic [31:0] dbase,
                          input logic [3:0] strb0, input logic [3:0] strb,
                          input int last_at, input int bdelay, input logic exp_err);
    int nb;
    int w0;
    nb = (last_at < 16) ? last_at + 1 : 16;
    w0 = int'(addr[7:2]) & 48;
    @(negedge clk);
    `CHK("w_rdy_idle", w_rdy, 1'b1)
    w_req  = 1'b1;
    w_addr = addr;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      w_req = 1'b0;
      `CHK("w_data_ready", w_data_ready, 1'b1)
      w_data_req = 1'b1;
      w_data     = dbase + 32'(k);
      w_strb     = (k == 0) ? strb0 : strb;
      w_last     = (k == last_at);
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) exp_mem[w0 + k][8*b +: 8] = w_data[8*b +: 8];
      end
    end
    @(negedge clk);
    w_data_req = 1'b0;
    w_last     = 1'b0;
    `CHK("b_valid_set", b_valid, 1'b1)
    `CHK("w_data_ready_off", w_data_ready, 1'b0)
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      `CHK("b_valid_hold", b_valid, 1'b1)
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    `CHK("b_valid_clr", b_valid, 1'b0)
    `CHK("w_rdy_back", w_rdy, 1'b1)
    `CHK("wr_err", wr_err, exp_err)
  endtask

  // Line read checked against exp_mem; toggle alternates r_data_ready on valid cycles.
  task automatic rd_line(input logic [31:0] addr, input logic toggle, input int exp_lat);
    int beats;
    int cyc;
    int first;
    int vcnt;
    int w0;
    w0    = int'(addr[7:2]) & 48;
    beats = 0;
    cyc   = 0;
    first = 0;
    vcnt  = 0;
    @(negedge clk);
    `CHK("r_rdy_idle", r_rdy, 1'b1)
    r_req        = 1'b1;
    r_addr       = addr;
    r_data_ready = 1'b1;
    while (beats < 16 && cyc < 80) begin
      @(negedge clk);
      r_req = 1'b0;
      cyc++;
      `CHK("r_rdy_busy", r_rdy, 1'b0)
      if (ret_valid) begin
        if (first == 0) first = cyc;
        r_data_ready = toggle ? ((vcnt % 2) == 0) : 1'b1;
        vcnt++;
        if (r_data_ready) begin
          `CHK("rd_data", r_data, exp_mem[w0 + beats])
          `CHK("rd_last", ret_last, (beats == 15))
          beats++;
        end else begin
          `CHK("rd_last_hold", ret_last, (beats == 15))
        end
      end
    end
    n_cmp++;
    if (beats < 16) begin
      n_err++;
      $error("FAIL rd_timeout: wait expired after %0d cycles with %0d beats", cyc, beats);
    end
    r_data_ready = 1'b1;
    `CHK("rd_beats", beats, 16)
    `CHK("rd_latency", first, exp_lat)
    if (!toggle) `CHK("rd_span", cyc - first + 1, 16)
    @(negedge clk);
    `CHK("ret_valid_drop", ret_valid, 1'b0)
    `CHK("r_rdy_back", r_rdy, 1'b1)
  endtask

  initial begin
    int rb;
    int beats;
    int cyc;

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({r_rdy, w_rdy, ret_valid, ret_last, w_data_ready, b_valid, wr_err, r_data} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $error("FAIL rst_state: r_rdy=%b w_rdy=%b ret_valid=%b ret_last=%b wdr=%b b_valid=%b wr_err=%b r_data=%0h",
             r_rdy, w_rdy, ret_valid, ret_last, w_data_ready, b_valid, wr_err, r_data);
    end
    `CHK("rst_r_rdy", r_rdy, 1'b1)
    `CHK("rst_w_rdy", w_rdy, 1'b1)
    `CHK("rst_ret_valid", ret_valid, 1'b0)
    `CHK("rst_ret_last", ret_last, 1'b0)
    `CHK("rst_w_data_ready", w_data_ready, 1'b0)
    `CHK("rst_b_valid", b_valid, 1'b0)
    `CHK("rst_wr_err", wr_err, 1'b0)
    `CHK("rst_r_data", r_data, 32'h0)
    rst = 1'b0;

    // Preload lines 1..3 with word i = 0xA000_0000 + i.
    wr_burst(32'h0000_0040, 32'hA000_0010, 4'hF, 4'hF, 15, 0, 1'b0);
    wr_burst(32'h0000_0080, 32'hA000_0020, 4'hF, 4'hF, 15, 0, 1'b0);
    wr_burst(32'h0000_00C0, 32'hA000_0030, 4'hF, 4'hF, 15, 0, 1'b0);

    // Plain read: first beat three cycles after acceptance, 16 back-to-back beats.
    rd_line(32'h0000_0040, 1'b0, 3);
    // Back-pressured read through an address whose upper bits alias line 1.
    rd_line(32'h0001_0040, 1'b1, 3);

    // Beat 0 writes only the low half of word 0x20; other beats are fully masked.
    wr_burst(32'h0000_0080, 32'h5555_6666, 4'h3, 4'h0, 15, 0, 1'b0);
    rd_line(32'h0000_0080, 1'b0, 3);

    // Full line write with delayed b_ready.
    wr_burst(32'h0000_0080, 32'h1111_0000, 4'hF, 4'hF, 15, 3, 1'b0);
    rd_line(32'h0000_0080, 1'b0, 3);

    // Early w_last on beat 7: short burst, sticky error, tail of line untouched.
    wr_burst(32'h0000_00C0, 32'hBBBB_0000, 4'hF, 4'hF, 7, 0, 1'b1);
    rd_line(32'h0000_00C0, 1'b0, 3);

    // Read accepted one cycle before a write of the same line: every load of
    // word j coincides with the write of word j, so the reader sees old data.
    rb = 0;
    r_data_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (ret_valid) begin
        `CHK("coll_old", r_data, exp_mem[16 + rb])
        rb++;
      end
      if (c == 18) `CHK("coll_b_valid", b_valid, 1'b1)
      r_req      = (c == 0);
      r_addr     = 32'h0000_0040;
      w_req      = (c == 1);
      w_addr     = 32'h0000_0040;
      w_data_req = (c >= 2) && (c <= 17);
      w_data     = 32'hCCCC_0000 + 32'(c - 2);
      w_strb     = 4'hF;
      w_last     = (c == 17);
      b_ready    = (c == 18);
    end
    `CHK("coll_beats", rb, 16)
    `CHK("coll_wr_err", wr_err, 1'b1)
    for (int j = 0; j < 16; j++) exp_mem[16 + j] = 32'hCCCC_0000 + 32'(j);
    rd_line(32'h0000_0040, 1'b0, 3);

    // Reset while beat 5 of a read is on the bus.
    beats = 0;
    cyc   = 0;
    @(negedge clk);
    r_req  = 1'b1;
    r_addr = 32'h0000_0080;
    while (cyc < 40) begin
      @(negedge clk);
      r_req = 1'b0;
      cyc++;
      if (ret_valid) begin
        if (beats == 5) break;
        `CHK("pre_rst_data", r_data, exp_mem[32 + beats])
        beats++;
      end
    end
    `CHK("pre_rst_beats", beats, 5)
    rst = 1'b1;
    #1;
    `CHK("mid_rst_ret_valid", ret_valid, 1'b0)
    `CHK("mid_rst_r_rdy", r_rdy, 1'b1)
    `CHK("mid_rst_r_data", r_data, 32'h0)
    `CHK("mid_rst_wr_err", wr_err, 1'b0)
    `CHK("mid_rst_b_valid", b_valid, 1'b0)
    @(negedge clk);
    rst = 1'b0;
    rd_line(32'h0000_0080, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
